// File: rtl/skew_cal_sched_if.sv
// Signal bundle between the skew sweep scheduler, the cal register block and the measure unit.
// master is the scheduler's view; slave is the view of whatever drives and observes it.
interface skew_cal_sched_if #(
    parameter int unsigned N_CH   = 8,
    parameter int unsigned CODE_W = 10
);
    localparam int unsigned IdxW = $clog2(N_CH);

    logic              start_i;
    logic              abort_i;
    logic [N_CH-1:0]   ch_mask_i;
    logic              busy_o;
    logic              done_o;
    logic              aborted_o;
    logic [IdxW-1:0]   ch_sel_o;
    logic              mes_run_o;
    logic              mes_rdy_i;
    logic [2:0]        mes_err_i;
    logic [CODE_W-1:0] mes_res_i;
    logic              res_we_o;
    logic [IdxW-1:0]   res_ch_o;
    logic [CODE_W-1:0] res_data_o;
    logic [2:0]        res_err_o;
    logic [N_CH-1:0]   err_mask_o;

    modport master (
        input  start_i, abort_i, ch_mask_i, mes_rdy_i, mes_err_i, mes_res_i,
        output busy_o, done_o, aborted_o, ch_sel_o, mes_run_o,
               res_we_o, res_ch_o, res_data_o, res_err_o, err_mask_o
    );

    modport slave (
        output start_i, abort_i, ch_mask_i, mes_rdy_i, mes_err_i, mes_res_i,
        input  busy_o, done_o, aborted_o, ch_sel_o, mes_run_o,
               res_we_o, res_ch_o, res_data_o, res_err_o, err_mask_o
    );
endinterface

// File: rtl/skew_cal_sched.sv
// Skew calibration sweep scheduler: walks enabled comparator channels lowest-first, runs one
// measurement per channel with retry and timeout, and writes back one result per channel.
module skew_cal_sched #(
    parameter int unsigned N_CH      = 8,
    parameter int unsigned CODE_W    = 10,
    parameter int unsigned TMO_W     = 16,
    parameter int unsigned MAX_RETRY = 2
) (
    input logic              clk_i,
    input logic              arstn_i,
    skew_cal_sched_if.master bus
);
    localparam int unsigned IdxW   = $clog2(N_CH);
    localparam int unsigned RetryW = $clog2(MAX_RETRY + 2);
    localparam logic [IdxW-1:0]   LastCh   = IdxW'(N_CH - 1);
    localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);
    // Compared before the increment, so the all-ones value lands on the last allowed cycle.
    localparam logic [TMO_W-1:0]  TmoLast  = {{(TMO_W - 1){1'b1}}, 1'b0};
    localparam logic [2:0]        ErrTmo   = 3'd7;

    typedef enum logic [2:0] {
        StIdle, StSelect, StArm, StRun, StDrop, StWrite, StDone
    } state_e;

    state_e              state_q, state_d;
    logic [N_CH-1:0]     mask_q, mask_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [IdxW-1:0]     ch_sel_q, ch_sel_d;
    logic [RetryW-1:0]   retry_q, retry_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                rdy_seen_q, rdy_seen_d;
    logic [2:0]          cap_err_q, cap_err_d;
    logic [N_CH-1:0]     err_mask_q, err_mask_d;
    logic [IdxW-1:0]     res_ch_q, res_ch_d;
    logic [CODE_W-1:0]   res_data_q, res_data_d;
    logic [2:0]          res_err_q, res_err_d;
    logic                aborted_q, aborted_d;
    logic                busy_q, done_q, run_q, we_q;
    logic                found;
    logic [IdxW-1:0]     pick;
    logic                abort_hit;

    // Lowest enabled channel at or above idx; descending loop so the lowest match wins.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask_q[i] && (i >= int'(idx_q))) begin
                found = 1'b1;
                pick  = IdxW'(i);
            end
        end
    end

    assign abort_hit = bus.abort_i &&
                       (state_q inside {StSelect, StArm, StRun, StDrop, StWrite});

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        idx_d      = idx_q;
        ch_sel_d   = ch_sel_q;
        retry_d    = retry_q;
        tmo_d      = tmo_q;
        rdy_seen_d = 1'b0;
        cap_err_d  = cap_err_q;
        err_mask_d = err_mask_q;
        res_ch_d   = res_ch_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;
        aborted_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start_i) begin
                    mask_d     = bus.ch_mask_i;
                    err_mask_d = '0;
                    idx_d      = '0;
                    state_d    = StSelect;
                end
            end
            StSelect: begin
                if (found) begin
                    ch_sel_d = pick;
                    retry_d  = '0;
                    state_d  = StArm;
                end else begin
                    state_d = StDone;
                end
            end
            StArm: begin
                tmo_d   = '0;
                state_d = StRun;
            end
            StRun: begin
                tmo_d      = tmo_q + TMO_W'(1);
                rdy_seen_d = bus.mes_rdy_i;
                if (bus.mes_err_i != 3'd0) begin
                    cap_err_d = bus.mes_err_i;
                    state_d   = StDrop;
                end else if (tmo_q == TmoLast) begin
                    cap_err_d = ErrTmo;
                    state_d   = StDrop;
                end else if (bus.mes_rdy_i && rdy_seen_q) begin
                    res_ch_d   = ch_sel_q;
                    res_data_d = bus.mes_res_i;
                    res_err_d  = 3'd0;
                    state_d    = StWrite;
                end
            end
            StDrop: begin
                if (retry_q < RetryMax) begin
                    retry_d = retry_q + RetryW'(1);
                    state_d = StArm;
                end else begin
                    res_ch_d   = ch_sel_q;
                    res_data_d = '0;
                    res_err_d  = cap_err_q;
                    state_d    = StWrite;
                end
            end
            StWrite: begin
                if (res_err_q != 3'd0) begin
                    err_mask_d[ch_sel_q] = 1'b1;
                end
                if (ch_sel_q != LastCh) begin
                    idx_d   = ch_sel_q + IdxW'(1);
                    state_d = StSelect;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort suppresses any result that was about to be written; a WRITE in flight still
        // records its error flag above.
        if (abort_hit) begin
            state_d    = StDone;
            aborted_d  = 1'b1;
            res_ch_d   = res_ch_q;
            res_data_d = res_data_q;
            res_err_d  = res_err_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            state_q    <= StIdle;
            mask_q     <= '0;
            idx_q      <= '0;
            ch_sel_q   <= '0;
            retry_q    <= '0;
            tmo_q      <= '0;
            rdy_seen_q <= 1'b0;
            cap_err_q  <= '0;
            err_mask_q <= '0;
            res_ch_q   <= '0;
            res_data_q <= '0;
            res_err_q  <= '0;
            aborted_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            run_q      <= 1'b0;
            we_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            idx_q      <= idx_d;
            ch_sel_q   <= ch_sel_d;
            retry_q    <= retry_d;
            tmo_q      <= tmo_d;
            rdy_seen_q <= rdy_seen_d;
            cap_err_q  <= cap_err_d;
            err_mask_q <= err_mask_d;
            res_ch_q   <= res_ch_d;
            res_data_q <= res_data_d;
            res_err_q  <= res_err_d;
            aborted_q  <= aborted_d;
            busy_q     <= (state_d != StIdle);
            done_q     <= (state_d == StDone);
            run_q      <= (state_d == StRun);
            we_q       <= (state_d == StWrite);
        end
    end

    assign bus.busy_o     = busy_q;
    assign bus.done_o     = done_q;
    assign bus.aborted_o  = aborted_q;
    assign bus.ch_sel_o   = ch_sel_q;
    assign bus.mes_run_o  = run_q;
    assign bus.res_we_o   = we_q;
    assign bus.res_ch_o   = res_ch_q;
    assign bus.res_data_o = res_data_q;
    assign bus.res_err_o  = res_err_q;
    assign bus.err_mask_o = err_mask_q;
endmodule

// File: tb/tb_skew_cal_sched.sv
// Randomised bench for skew_cal_sched: a scripted measure unit plays per-attempt plans and a
// plan-level model predicts the write sequence, error mask and termination of each sweep.
module tb_skew_cal_sched;
    localparam int N  = 8;
    localparam int CW = 10;
    localparam int TW = 5;
    localparam int MR = 2;
    localparam int T  = (1 << TW) - 1;
    localparam int K_OK = 0, K_ERR = 1, K_SIL = 2;

    typedef struct {
        int ch;
        int data;
        int err;
        int cyc;
    } wr_t;

    logic clk;
    logic arstn;
    skew_cal_sched_if #(.N_CH(N), .CODE_W(CW)) bus ();

    skew_cal_sched #(.N_CH(N), .CODE_W(CW), .TMO_W(TW), .MAX_RETRY(MR)) dut (
        .clk_i   (clk),
        .arstn_i (arstn),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int p_kind [N][MR+1];
    int p_lat  [N][MR+1];
    int p_res  [N][MR+1];
    int p_err  [N][MR+1];

    wr_t wq[$];
    int  att_cnt [N];
    int  done_cnt;
    int  done_cyc;
    bit  done_ab;
    int  cyc;
    int  last_run_len;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Measure-unit stand-in and output monitor, both sampling 1 time unit after each edge.
    initial begin : bfm
        int  cur_ch;
        int  cur_att;
        int  run_cnt;
        bit  prev_run;
        cur_ch = 0; cur_att = 0; run_cnt = 0; prev_run = 1'b0;
        cyc = 0; done_cnt = 0; done_cyc = 0; done_ab = 1'b0; last_run_len = 0;
        bus.mes_rdy_i = 1'b0;
        bus.mes_err_i = 3'd0;
        bus.mes_res_i = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.res_we_o) begin
                wq.push_back('{ch: int'(bus.res_ch_o), data: int'(bus.res_data_o),
                               err: int'(bus.res_err_o), cyc: cyc});
            end
            if (bus.done_o) begin
                done_cnt++;
                done_cyc = cyc;
                done_ab  = bus.aborted_o;
            end
            if (bus.mes_run_o && !prev_run) begin
                cur_ch  = int'(bus.ch_sel_o);
                cur_att = att_cnt[cur_ch];
                att_cnt[cur_ch]++;
                run_cnt = 0;
            end
            if (!bus.mes_run_o && prev_run) last_run_len = run_cnt;
            if (bus.mes_run_o) run_cnt++;
            prev_run = bus.mes_run_o;

            bus.mes_rdy_i = 1'b0;
            bus.mes_err_i = 3'd0;
            bus.mes_res_i = '0;
            if (bus.mes_run_o && cur_att <= MR) begin
                if (p_kind[cur_ch][cur_att] == K_OK && run_cnt >= p_lat[cur_ch][cur_att]) begin
                    bus.mes_rdy_i = 1'b1;
                    bus.mes_res_i = CW'(p_res[cur_ch][cur_att]);
                end else if (p_kind[cur_ch][cur_att] == K_ERR &&
                             run_cnt == p_lat[cur_ch][cur_att]) begin
                    bus.mes_err_i = 3'(p_err[cur_ch][cur_att]);
                end
            end
        end
    end

    task automatic set_plan(input int ch, input int kind, input int lat, input int res,
                            input int err);
        for (int a = 0; a <= MR; a++) begin
            p_kind[ch][a] = kind;
            p_lat[ch][a]  = lat;
            p_res[ch][a]  = res;
            p_err[ch][a]  = err;
        end
    endtask

    task automatic random_plans();
        int r;
        for (int ch = 0; ch < N; ch++) begin
            for (int a = 0; a <= MR; a++) begin
                r = int'($urandom_range(0, 5));
                p_kind[ch][a] = (r <= 2) ? K_OK : ((r <= 4) ? K_ERR : K_SIL);
                p_lat[ch][a]  = (p_kind[ch][a] == K_OK) ? int'($urandom_range(1, 34))
                                                        : int'($urandom_range(1, 12));
                p_res[ch][a]  = int'($urandom_range(0, (1 << CW) - 1));
                p_err[ch][a]  = int'($urandom_range(1, 6));
            end
        end
    endtask

    // Outcome of one attempt: success needs rdy on two RUN cycles before the timeout cycle,
    // an error on or before the timeout cycle wins, otherwise the attempt times out.
    function automatic void outcome(input int ch, input int a, output bit ok, output int data,
                                    output int code);
        ok = 1'b0;
        data = 0;
        code = 7;
        if (p_kind[ch][a] == K_OK && p_lat[ch][a] + 1 < T) begin
            ok = 1'b1;
            data = p_res[ch][a];
            code = 0;
        end else if (p_kind[ch][a] == K_ERR && p_lat[ch][a] <= T) begin
            code = p_err[ch][a];
        end
    endfunction

    task automatic run_sweep(input logic [N-1:0] mask, input int abort_ch,
                             input bit abort_with_start, input string tag);
        wr_t          exp_q[$];
        int           exp_att [N];
        logic [N-1:0] exp_em;
        int           k;
        bit           ok;
        int           d;
        int           c;
        int           hi;
        wq.delete();
        done_cnt = 0;
        for (int i = 0; i < N; i++) att_cnt[i] = 0;

        @(posedge clk);
        #2;
        bus.ch_mask_i = mask;
        bus.start_i   = 1'b1;
        bus.abort_i   = abort_with_start;
        @(posedge clk);
        #2;
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;

        if (abort_ch >= 0) begin
            k = 0;
            while (!(bus.mes_run_o && int'(bus.ch_sel_o) == abort_ch) && k < 3000) begin
                @(posedge clk);
                #2;
                k++;
            end
            check_eq({tag, "_abort_reach"}, 64'(k < 3000), 64'd1);
            bus.abort_i = 1'b1;
            @(posedge clk);
            #1;
            check_eq({tag, "_abort_run_low"}, 64'(bus.mes_run_o), 64'd0);
            check_eq({tag, "_abort_done"}, 64'(bus.done_o), 64'd1);
            check_eq({tag, "_abort_flag"}, 64'(bus.aborted_o), 64'd1);
            #1;
            bus.abort_i = 1'b0;
        end

        k = 0;
        while (done_cnt == 0 && k < 5000) begin
            @(posedge clk);
            #2;
            k++;
        end
        check_eq({tag, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
        repeat (2) @(posedge clk);
        #2;

        exp_em = '0;
        hi = -1;
        for (int ch = 0; ch < N; ch++) begin
            exp_att[ch] = 0;
            if (mask[ch] && (abort_ch < 0 || ch < abort_ch)) begin
                c = 7;
                d = 0;
                for (int a = 0; a <= MR; a++) begin
                    exp_att[ch] = a + 1;
                    outcome(ch, a, ok, d, c);
                    if (ok) break;
                end
                exp_q.push_back('{ch: ch, data: ok ? d : 0, err: ok ? 0 : c, cyc: 0});
                if (!ok) exp_em[ch] = 1'b1;
                hi = ch;
            end
        end

        check_eq({tag, "_nwrites"}, 64'(wq.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wq.size(); i++) begin
            check_eq({tag, "_wr_ch"}, 64'(wq[i].ch), 64'(exp_q[i].ch));
            check_eq({tag, "_wr_data"}, 64'(wq[i].data), 64'(exp_q[i].data));
            check_eq({tag, "_wr_err"}, 64'(wq[i].err), 64'(exp_q[i].err));
        end
        for (int ch = 0; ch < N; ch++) begin
            if (mask[ch] && (abort_ch < 0 || ch < abort_ch)) begin
                check_eq({tag, "_attempts"}, 64'(att_cnt[ch]), 64'(exp_att[ch]));
            end
        end
        check_eq({tag, "_err_mask"}, 64'(bus.err_mask_o), 64'(exp_em));
        check_eq({tag, "_done_once"}, 64'(done_cnt), 64'd1);
        check_eq({tag, "_aborted"}, 64'(done_ab), 64'(abort_ch >= 0));
        check_eq({tag, "_idle"}, 64'(bus.busy_o), 64'd0);
        if (abort_ch < 0 && hi >= 0) begin
            check_eq({tag, "_ch_sel_hold"}, 64'(bus.ch_sel_o), 64'(hi));
            check_eq({tag, "_res_ch_hold"}, 64'(bus.res_ch_o), 64'(hi));
        end
        if (abort_ch < 0 && mask[N-1] && wq.size() > 0) begin
            check_eq({tag, "_done_after_last"}, 64'(done_cyc), 64'(wq[wq.size()-1].cyc + 1));
        end
    endtask

    initial begin : main
        int k;
        logic [N-1:0] m;
        arstn         = 1'b0;
        bus.start_i   = 1'b0;
        bus.abort_i   = 1'b0;
        bus.ch_mask_i = '0;
        for (int ch = 0; ch < N; ch++) set_plan(ch, K_SIL, 1, 0, 0);
        for (int i = 0; i < N; i++) att_cnt[i] = 0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 64'(bus.busy_o), 64'd0);
        check_eq("rst_done", 64'(bus.done_o), 64'd0);
        check_eq("rst_run", 64'(bus.mes_run_o), 64'd0);
        check_eq("rst_we", 64'(bus.res_we_o), 64'd0);
        check_eq("rst_ch_sel", 64'(bus.ch_sel_o), 64'd0);
        check_eq("rst_err_mask", 64'(bus.err_mask_o), 64'd0);
        check_eq("rst_res_data", 64'(bus.res_data_o), 64'd0);
        #1;
        arstn = 1'b1;

        set_plan(0, K_OK, 20, 37, 0);
        set_plan(2, K_OK, 20, 5, 0);
        run_sweep(8'b0000_0101, -1, 1'b0, "two_ch");

        set_plan(0, K_ERR, 3, 0, 1);
        run_sweep(8'h01, -1, 1'b0, "err_retry");

        set_plan(7, K_SIL, 1, 0, 0);
        run_sweep(8'h80, -1, 1'b0, "timeout");
        check_eq("timeout_run_len", 64'(last_run_len), 64'(T));

        for (int ch = 0; ch < N; ch++) set_plan(ch, K_OK, 4, 100 + ch, 0);
        set_plan(3, K_OK, 10, 200, 0);
        run_sweep(8'hFF, 3, 1'b0, "abort");

        // Zero mask: SELECT finds nothing, so done lands two cycles after start.
        wq.delete();
        done_cnt = 0;
        @(posedge clk);
        #2;
        bus.ch_mask_i = '0;
        bus.start_i   = 1'b1;
        @(posedge clk);
        #1;
        check_eq("zero_busy", 64'(bus.busy_o), 64'd1);
        check_eq("zero_done_early", 64'(bus.done_o), 64'd0);
        #1;
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        check_eq("zero_done", 64'(bus.done_o), 64'd1);
        check_eq("zero_aborted", 64'(bus.aborted_o), 64'd0);
        @(posedge clk);
        #1;
        check_eq("zero_done_pulse", 64'(bus.done_o), 64'd0);
        check_eq("zero_idle", 64'(bus.busy_o), 64'd0);
        check_eq("zero_no_write", 64'(wq.size()), 64'd0);

        // Reset in the middle of a RUN.
        for (int ch = 0; ch < N; ch++) set_plan(ch, K_SIL, 1, 0, 0);
        @(posedge clk);
        #2;
        bus.ch_mask_i = 8'hFF;
        bus.start_i   = 1'b1;
        @(posedge clk);
        #2;
        bus.start_i = 1'b0;
        k = 0;
        while (!bus.mes_run_o && k < 100) begin
            @(posedge clk);
            #2;
            k++;
        end
        check_eq("mid_rst_reach_run", 64'(k < 100), 64'd1);
        arstn = 1'b0;
        @(posedge clk);
        #1;
        check_eq("mid_rst_run", 64'(bus.mes_run_o), 64'd0);
        check_eq("mid_rst_busy", 64'(bus.busy_o), 64'd0);
        check_eq("mid_rst_res_ch", 64'(bus.res_ch_o), 64'd0);
        check_eq("mid_rst_res_err", 64'(bus.res_err_o), 64'd0);
        check_eq("mid_rst_err_mask", 64'(bus.err_mask_o), 64'd0);
        wq.delete();
        done_cnt = 0;
        @(posedge clk);
        #2;
        arstn = 1'b1;
        repeat (40) @(posedge clk);
        #2;
        check_eq("mid_rst_no_write", 64'(wq.size()), 64'd0);
        check_eq("mid_rst_no_done", 64'(done_cnt), 64'd0);

        random_plans();
        run_sweep(8'hA5, -1, 1'b0, "after_rst");

        set_plan(0, K_OK, 2, 321, 0);
        run_sweep(8'h01, -1, 1'b1, "start_abort");

        for (int s = 0; s < 6; s++) begin
            random_plans();
            m = N'($urandom_range(1, (1 << N) - 1));
            run_sweep(m, -1, 1'b0, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
